// File: rtl/count_scheduler.sv
// count_scheduler
//   Shares one external WIDTH-bit up-counter between NREQ requesters. Requests
//   are granted round-robin. The owner's delay is latched. The block then clears
//   the counter, enables it for that many cycles, and acks the owner.
//   Ports:
//     clk        clock, rising edge
//     a_rst      asynchronous reset, active-low
//     sreset_i   synchronous reset, active-high
//     req_i      per-requester request level, held until ack
//     req_len_i  per-requester delay, slice i = [i*WIDTH +: WIDTH]
//     cnt_val_i  current value of the external counter
//     grant_o    one-hot owner, valid from CLEAR through DONE
//     ack_o      one-cycle completion pulse to the owner
//     busy_o     high whenever the FSM is not idle
//     cnt_clr_o  counter synchronous clear
//     cnt_en_o   counter increment enable
//   All outputs are flops loaded from the next-state decode, so they line up
//   with the state register and have no combinational path from req_i or cnt_val_i.
module count_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic                  sreset_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] req_len_i,
  input  logic [WIDTH-1:0]      cnt_val_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ-1:0]       ack_o,
  output logic                  busy_o,
  output logic                  cnt_clr_o,
  output logic                  cnt_en_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NREQ - 1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  len_q, len_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, clr_q, en_q;

  logic              found;
  logic [IdxW-1:0]   pick_idx;
  logic [NREQ-1:0]   owner_oh;

  // Round-robin pick: first set request scanning rr_ptr+1 upward, wrapping.
  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      logic [IdxW-1:0] pos;
      pos = IdxW'((32'(rr_ptr_q) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found    = 1'b1;
        pick_idx = pos;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d   = pick_idx;
          len_d   = req_len_i[32'(pick_idx)*WIDTH +: WIDTH];
          state_d = StClear;
        end
      end
      StClear: begin
        if (!req_i[idx_q]) begin
          state_d  = StIdle;
          rr_ptr_d = idx_q;
        end else if (len_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        // The counter read 0 in the first RUN cycle, so leaving at len-1
        // gives exactly len enable cycles. len_q is never 0 here.
        if (!req_i[idx_q]) begin
          state_d  = StIdle;
          rr_ptr_d = idx_q;
        end else if (cnt_val_i == len_q - One) begin
          state_d = StDone;
        end
      end
      StDone: begin
        rr_ptr_d = idx_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (sreset_i) begin
      state_d  = StIdle;
      rr_ptr_d = LastIdx;
    end
  end

  always_comb begin
    owner_oh = NREQ'(1) << idx_d;
    grant_d  = (state_d != StIdle) ? owner_oh : '0;
    ack_d    = (state_d == StDone) ? owner_oh : '0;
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rr_ptr_q <= LastIdx;
      len_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      busy_q   <= (state_d != StIdle);
      clr_q    <= (state_d == StClear);
      en_q     <= (state_d == StRun);
    end
  end

  assign grant_o   = grant_q;
  assign ack_o     = ack_q;
  assign busy_o    = busy_q;
  assign cnt_clr_o = clr_q;
  assign cnt_en_o  = en_q;

endmodule

// File: tb/tb_count_scheduler.sv
// Bench for count_scheduler (NREQ=4, WIDTH=4) with a model of the external
// counter. Stimulus pushes expected grants and acks into queues. A monitor
// pops an entry and compares it whenever the DUT shows a grant (cnt_clr) or an ack.
module tb_count_scheduler;

  typedef struct {
    int vec;
    int cyc;
    int len;
  } exp_t;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        sreset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  cnt_q;
  logic [3:0]  grant, ack;
  logic        busy, cnt_clr, cnt_en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t gq[$];
  exp_t aq[$];

  count_scheduler #(.NREQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .a_rst     (a_rst),
    .sreset_i  (sreset),
    .req_i     (req),
    .req_len_i (req_len),
    .cnt_val_i (cnt_q),
    .grant_o   (grant),
    .ack_o     (ack),
    .busy_o    (busy),
    .cnt_clr_o (cnt_clr),
    .cnt_en_o  (cnt_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External counter with synchronous clear and enable.
  initial cnt_q = '0;
  always @(posedge clk) begin
    if (cnt_clr)     cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*4 +: 4] = 4'(v);
  endtask

  task automatic exp_grant(input int vec, input int c);
    gq.push_back('{vec: vec, cyc: c, len: 0});
  endtask

  task automatic exp_ack(input int vec, input int c, input int len);
    aq.push_back('{vec: vec, cyc: c, len: len});
  endtask

  task automatic chk_idle_outs(input string name);
    chk({name, "_grant"}, int'(grant), 0);
    chk({name, "_ack"}, int'(ack), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_clr"}, int'(cnt_clr), 0);
    chk({name, "_en"}, int'(cnt_en), 0);
  endtask

  // Run until n acks have been seen and the DUT is idle again. Owners drop
  // their request on ack when drop is set. All requests drop at the n-th ack.
  task automatic serve(input int n, input bit drop);
    int acks;
    acks = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack != 4'd0) begin
        acks++;
        if (drop) req = req & ~ack;
        if (acks >= n) req = '0;
      end
      if (acks >= n && !busy) return;
    end
    total++;
    bad++;
    $display("FAIL serve_timeout: got %0d acks expected %0d", acks, n);
    req = '0;
  endtask

  // Monitor: compares each grant and ack against the head of its queue.
  int   en_cnt = 0;
  int   cur_grant = 0;
  exp_t e;
  always @(negedge clk) begin
    if (a_rst) begin
      if (cnt_clr) begin
        en_cnt = 0;
        if (gq.size() == 0) begin
          chk("grant_unexpected", int'(grant), 0);
        end else begin
          e = gq.pop_front();
          cur_grant = e.vec;
          chk("grant_vec", int'(grant), e.vec);
          chk("grant_cycle", cyc, e.cyc);
        end
      end
      if (cnt_en) begin
        en_cnt++;
        chk("grant_hold_run", int'(grant), cur_grant);
      end
      if (ack != 4'd0) begin
        if (aq.size() == 0) begin
          chk("ack_unexpected", int'(ack), 0);
        end else begin
          e = aq.pop_front();
          chk("ack_vec", int'(ack), e.vec);
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_cnt_val", int'(cnt_q), e.len);
          chk("ack_en_cycles", en_cnt, e.len);
          chk("ack_grant", int'(grant), e.vec);
        end
      end
    end
  end

  int c;

  initial begin
    a_rst   = 1'b1;
    sreset  = 1'b0;
    req     = '0;
    req_len = '0;
    #2 a_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outs("reset");
    a_rst = 1'b1;
    @(negedge clk);

    // 1: single request, len 5.
    c = cyc;
    set_len(0, 5);
    req = 4'b0001;
    exp_grant(1, c + 1);
    exp_ack(1, c + 7, 5);
    serve(1, 1'b1);

    // 2: all four requesting, held, len 2. Fresh pointer so 0 goes first.
    sreset = 1'b1;
    @(negedge clk);
    sreset = 1'b0;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 4; i++) set_len(i, 2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_grant(1 << (k % 4), c + 1 + 5 * k);
      exp_ack(1 << (k % 4), c + 4 + 5 * k, 2);
    end
    serve(5, 1'b0);

    // 3: zero length on requester 2.
    @(negedge clk);
    c = cyc;
    set_len(2, 0);
    req = 4'b0100;
    exp_grant(4, c + 1);
    exp_ack(4, c + 2, 0);
    serve(1, 1'b1);

    // 4: abort requester 1 on its third RUN cycle; requester 2 is pending.
    @(negedge clk);
    c = cyc;
    set_len(1, 10);
    set_len(2, 1);
    req = 4'b0110;
    exp_grant(2, c + 1);
    repeat (4) @(negedge clk);
    chk("abort_run_en", int'(cnt_en), 1);
    req[1] = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_grant", int'(grant), 0);
    chk("abort_en", int'(cnt_en), 0);
    exp_grant(4, c + 6);
    exp_ack(4, c + 8, 1);
    serve(1, 1'b1);

    // 5: async reset mid-RUN, then sync reset mid-RUN.
    @(negedge clk);
    c = cyc;
    set_len(0, 10);
    req = 4'b0001;
    exp_grant(1, c + 1);
    repeat (4) @(negedge clk);
    a_rst = 1'b0;
    #1 chk_idle_outs("arst");
    @(negedge clk);
    a_rst = 1'b1;
    c = cyc;
    set_len(3, 3);
    req = 4'b1001;
    exp_grant(1, c + 1);
    repeat (3) @(negedge clk);
    sreset = 1'b1;
    @(negedge clk);
    chk_idle_outs("sreset");
    sreset = 1'b0;
    c = cyc;
    exp_grant(1, c + 1);
    exp_ack(1, c + 12, 10);
    exp_grant(8, c + 14);
    exp_ack(8, c + 18, 3);
    serve(2, 1'b1);

    // 6: full-scale length 15; owner's later len change must be ignored.
    @(negedge clk);
    c = cyc;
    set_len(3, 15);
    req = 4'b1000;
    exp_grant(8, c + 1);
    exp_ack(8, c + 17, 15);
    repeat (2) @(negedge clk);
    set_len(3, 2);
    serve(1, 1'b1);

    repeat (4) @(negedge clk);
    chk("grant_queue_drained", gq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);
    chk_idle_outs("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
